spi_slave_rw: RTL and testbench

//  Parametrised SPI slave (mode 0 / mode 2 via CPOL) bridging an SPI master (e.g. RPi) to on-chip registers.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_sync_edge.sv | 27 ++
 rtl/spi_slave_rw.sv | 129 ++++++++++++
 tb/tb_spi_slave_rw.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and frame geometry for the SPI register slave.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, HDR, FETCH, DATA, TAIL} spi_state_t;
  localparam int RW_POS = 0;
  function automatic int frame_len(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one async input with rise/fall detect on the synced level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end
  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_slave_rw.sv
// spi_slave_rw: SPI slave carrying RW/address/payload frames onto a register read/write port.
module spi_slave_rw
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter bit CPOL        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              SPI_CLK,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              RdStrobe,
  input  logic [DATA_W-1:0] RdData,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic              WrEn,
  output logic              Busy,
  output logic              FrameErr
);
  localparam int N       = frame_len(ADDR_W, DATA_W);
  localparam int HDR_LEN = RW_POS + 1 + ADDR_W;
  localparam int CW      = $clog2(N + 1);
  localparam int SH      = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

  logic             w_cs, w_sck_rise, w_sck_fall, w_mosi;
  logic [4:0]       w_unused;
  spi_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [SH-2:0]    r_rx;
  logic [SH-1:0]    w_shift;
  logic [DATA_W-1:0] r_tx, r_wr_data;
  logic [ADDR_W-1:0] r_addr, r_rd_addr, r_wr_addr;
  logic             r_rw, r_miso, r_rd_stb, r_wr_en, r_ferr;
  logic             w_last_hdr, w_last_bit, w_rd_stb, w_wr_en, w_ferr;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(SPI_CLK ^ CPOL),
    .o_q(w_unused[0]), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(SPI_CS),
    .o_q(w_cs), .o_rise(w_unused[1]), .o_fall(w_unused[2]));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .Clk(Clk), .Reset_n(Reset_n), .i_d(SPI_MOSI),
    .o_q(w_mosi), .o_rise(w_unused[3]), .o_fall(w_unused[4]));

  // w_shift is the receive register as it will look once the current capture is taken
  assign w_shift    = {r_rx, w_mosi};
  assign w_last_hdr = w_sck_rise && r_cnt == CW'(HDR_LEN - 1);
  assign w_last_bit = w_sck_rise && r_cnt == CW'(N - 1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_cs ? IDLE : HDR;
      HDR:     w_state_nxt = w_cs ? IDLE : w_last_hdr ? (w_shift[ADDR_W] ? DATA : FETCH) : HDR;
      FETCH:   w_state_nxt = w_cs ? IDLE : r_rd_stb ? FETCH : DATA;
      DATA:    w_state_nxt = w_last_bit ? TAIL : w_cs ? IDLE : DATA;
      TAIL:    w_state_nxt = w_cs ? IDLE : TAIL;
      default: w_state_nxt = IDLE;
    endcase
  end

  // a capture coinciding with CS rising still completes the frame
  always_comb begin
    w_rd_stb = r_state == HDR && !w_cs && w_last_hdr && !w_shift[ADDR_W];
    w_wr_en  = r_state == DATA && w_last_bit && r_rw;
    w_ferr   = w_cs && (r_state == HDR || r_state == FETCH || (r_state == DATA && !w_last_bit));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt     <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_miso    <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_ferr    <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_rd_stb <= w_rd_stb;
      r_wr_en  <= w_wr_en;
      r_ferr   <= w_ferr;
      if (w_rd_stb) r_rd_addr <= w_shift[ADDR_W-1:0];
      if (w_wr_en) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_shift[DATA_W-1:0];
      end
      if (r_state == IDLE) begin
        r_cnt <= '0;
        r_rx  <= '0;
      end else if ((r_state == HDR || r_state == DATA) && w_sck_rise) begin
        r_rx  <= w_shift[SH-2:0];
        r_cnt <= (r_cnt == CW'(N)) ? r_cnt : r_cnt + 1'b1;
      end
      if (r_state == HDR && w_last_hdr) begin
        r_addr <= w_shift[ADDR_W-1:0];
        r_rw   <= w_shift[ADDR_W];
      end
      if (r_state == IDLE) r_tx <= '0;
      else if (r_state == FETCH && !r_rd_stb) r_tx <= RdData;
      else if (r_state == DATA && w_sck_fall && !r_rw) r_tx <= r_tx << 1;
      r_miso <= (r_state == DATA && !r_rw) ? (w_sck_fall ? r_tx[DATA_W-1] : r_miso) : 1'b0;
    end
  end

  assign SPI_MISO = r_miso;
  assign RdAddr   = r_rd_addr;
  assign RdStrobe = r_rd_stb;
  assign WrAddr   = r_wr_addr;
  assign WrData   = r_wr_data;
  assign WrEn     = r_wr_en;
  assign Busy     = ~w_cs;
  assign FrameErr = r_ferr;
endmodule

// File: tb/tb_spi_slave_rw.sv
// tb_spi_slave_rw: scoreboard bench driving a CPOL=0 and a CPOL=1 slave with directed frames.
module tb_spi_slave_rw;
  typedef struct {
    int          dut;
    int          kind;
    logic [7:0]  a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  sck, cs, mosi, miso, rd_stb, wr_en, busy, ferr;
  logic [7:0]  rd_addr [2];
  logic [7:0]  wr_addr [2];
  logic [31:0] rd_data [2];
  logic [31:0] wr_data [2];
  ev_t         exp_q [$];
  logic [31:0] exp_rd_q [$];
  logic [31:0] got_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rx;
  logic        ma;

  always #5 clk = ~clk;

  spi_slave_rw #(.ADDR_W(8), .DATA_W(32), .CPOL(1'b0), .SYNC_STAGES(2)) u_dut0 (
    .Clk(clk), .Reset_n(rst_n), .SPI_CLK(sck[0]), .SPI_CS(cs[0]), .SPI_MOSI(mosi[0]),
    .SPI_MISO(miso[0]), .RdAddr(rd_addr[0]), .RdStrobe(rd_stb[0]), .RdData(rd_data[0]),
    .WrAddr(wr_addr[0]), .WrData(wr_data[0]), .WrEn(wr_en[0]), .Busy(busy[0]), .FrameErr(ferr[0]));
  spi_slave_rw #(.ADDR_W(8), .DATA_W(32), .CPOL(1'b1), .SYNC_STAGES(2)) u_dut1 (
    .Clk(clk), .Reset_n(rst_n), .SPI_CLK(sck[1]), .SPI_CS(cs[1]), .SPI_MOSI(mosi[1]),
    .SPI_MISO(miso[1]), .RdAddr(rd_addr[1]), .RdStrobe(rd_stb[1]), .RdData(rd_data[1]),
    .WrAddr(wr_addr[1]), .WrData(wr_data[1]), .WrEn(wr_en[1]), .Busy(busy[1]), .FrameErr(ferr[1]));

  function automatic logic [31:0] mem(input logic [7:0] a);
    return (a == 8'h12) ? 32'hCAFEF00D : {4{a}};
  endfunction

  initial begin
    rd_data[0] = '0;
    rd_data[1] = '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) if (rd_stb[i]) rd_data[i] <= mem(rd_addr[i]);
  end

  task automatic exp_ev(input int dut, input int kind, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back('{dut: dut, kind: kind, a: a, d: d});
  endtask

  task automatic check_ev(input int dut, input int kind, input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event dut%0d kind%0d got a=%h d=%h required no event", dut, kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != dut || e.kind != kind || e.a !== a || e.d !== d) begin
        errors++;
        $display("FAIL event got dut%0d kind%0d a=%h d=%h required dut%0d kind%0d a=%h d=%h",
                 dut, kind, a, d, e.dut, e.kind, e.a, e.d);
      end
    end
  endtask

  task automatic cmp(input string n, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", n, got, req);
    end
  endtask

  // kind 0 = read strobe, 1 = write commit, 2 = frame error
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i])  check_ev(i, 1, wr_addr[i], wr_data[i]);
      if (rd_stb[i]) check_ev(i, 0, rd_addr[i], 32'h0);
      if (ferr[i])   check_ev(i, 2, 8'h0, 32'h0);
    end
    if (got_q.size() > 0) begin
      if (exp_rd_q.size() == 0) cmp("read_unexpected", {32'h0, got_q.pop_front()}, 64'hFFFF_FFFF_FFFF_FFFF);
      else cmp("read_data", {32'h0, got_q.pop_front()}, {32'h0, exp_rd_q.pop_front()});
    end
  end

  function automatic logic [52:0] outs(input int i);
    return {miso[i], rd_stb[i], wr_en[i], busy[i], ferr[i], rd_addr[i], wr_addr[i], wr_data[i]};
  endfunction

  task automatic frame(input int sel, input logic rw, input logic [7:0] a, input logic [31:0] d,
                       input int nbits, input int gap, input int abort_bit,
                       output logic [31:0] r, output logic m_any);
    logic [40:0] v;
    v = {rw, a, d};
    r = '0;
    m_any = 1'b0;
    cs[sel] = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_bit) rst_n = 1'b0;
      mosi[sel] = v[40-i];
      repeat (8) @(posedge clk);
      r = {r[30:0], miso[sel]};
      m_any = m_any | miso[sel];
      sck[sel] = (sel == 1) ? 1'b0 : 1'b1;
      repeat (8) @(posedge clk);
      sck[sel] = (sel == 1) ? 1'b1 : 1'b0;
    end
    repeat (8) @(posedge clk);
    cs[sel] = 1'b1;
    mosi[sel] = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    sck = 2'b10;
    cs = 2'b11;
    mosi = 2'b00;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_outs0", {11'h0, outs(0)}, 64'h0);
    cmp("reset_outs1", {11'h0, outs(1)}, 64'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    exp_ev(0, 1, 8'h05, 32'hDEADBEEF);
    frame(0, 1'b1, 8'h05, 32'hDEADBEEF, 41, 20, -1, rx, ma);
    cmp("write_miso0", {63'h0, ma}, 64'h0);
    exp_ev(0, 0, 8'h12, 32'h0);
    exp_rd_q.push_back(32'hCAFEF00D);
    frame(0, 1'b0, 8'h12, 32'h0, 41, 20, -1, rx, ma);
    got_q.push_back(rx);
    exp_ev(0, 2, 8'h0, 32'h0);
    frame(0, 1'b1, 8'h33, 32'h11112222, 20, 20, -1, rx, ma);
    @(negedge clk);
    cmp("ferr_busy", {62'h0, busy}, 64'h0);
    exp_ev(0, 1, 8'h44, 32'h01234567);
    frame(0, 1'b1, 8'h44, 32'h01234567, 41, 20, -1, rx, ma);
    exp_ev(1, 1, 8'h05, 32'hDEADBEEF);
    frame(1, 1'b1, 8'h05, 32'hDEADBEEF, 41, 20, -1, rx, ma);
    cmp("cpol1_write_miso0", {63'h0, ma}, 64'h0);
    exp_ev(1, 0, 8'h12, 32'h0);
    exp_rd_q.push_back(32'hCAFEF00D);
    frame(1, 1'b0, 8'h12, 32'h0, 41, 20, -1, rx, ma);
    got_q.push_back(rx);
    exp_ev(0, 1, 8'h01, 32'hA5A5A5A5);
    exp_ev(0, 1, 8'h02, 32'h5A5A5A5A);
    frame(0, 1'b1, 8'h01, 32'hA5A5A5A5, 41, 6, -1, rx, ma);
    frame(0, 1'b1, 8'h02, 32'h5A5A5A5A, 41, 20, -1, rx, ma);
    frame(0, 1'b1, 8'h77, 32'hFFFF0000, 41, 0, 20, rx, ma);
    @(negedge clk);
    cmp("abort_outs0", {11'h0, outs(0)}, 64'h0);
    cmp("abort_outs1", {11'h0, outs(1)}, 64'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    exp_ev(0, 1, 8'h78, 32'h87654321);
    frame(0, 1'b1, 8'h78, 32'h87654321, 41, 20, -1, rx, ma);
    repeat (50) @(posedge clk);
    cmp("events_left", {32'h0, exp_q.size()}, 64'h0);
    cmp("reads_left", {32'h0, exp_rd_q.size()}, 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
